// File: rtl/axi_slave_pkg.sv
// Shared AXI widths, response codes and FSM state encoding for the AXI-to-SRAM slave.
package axi_slave_pkg;

  localparam int unsigned AxiIdWidth   = 8;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiLenWidth  = 4;
  localparam int unsigned AxiStrbWidth = 4;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWData,
    StBResp,
    StRFetch,
    StRData
  } slv_state_e;

endpackage

// File: rtl/axi_slave_arb.sv
// Two-request round-robin arbiter between the AW and AR channels.
// Remembers the last grant; write wins the first contention after reset.
module axi_slave_arb (
  input  logic ACLK,
  input  logic ARESET,
  input  logic en_i,
  input  logic aw_req_i,
  input  logic ar_req_i,
  output logic aw_gnt_o,
  output logic ar_gnt_o
);

  logic last_wr_q;

  always_comb begin
    aw_gnt_o = en_i & aw_req_i & (~ar_req_i | ~last_wr_q);
    ar_gnt_o = en_i & ar_req_i & (~aw_req_i |  last_wr_q);
  end

  // A grant is a handshake, since ready is driven straight from the grant.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_wr_q <= 1'b0;
    end else if (aw_gnt_o) begin
      last_wr_q <= 1'b1;
    end else if (ar_gnt_o) begin
      last_wr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_slave_mem_if.sv
// AXI4 slave bridging single-outstanding INCR bursts to a 32-bit synchronous SRAM port.
module axi_slave_mem_if
  import axi_slave_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [AxiIdWidth-1:0]    AWID_S,
  input  logic [AxiAddrWidth-1:0]  AWADDR_S,
  input  logic [AxiLenWidth-1:0]   AWLEN_S,
  input  logic [2:0]               AWSIZE_S,
  input  logic [1:0]               AWBURST_S,
  input  logic                     AWVALID_S,
  output logic                     AWREADY_S,
  input  logic [AxiDataWidth-1:0]  WDATA_S,
  input  logic [AxiStrbWidth-1:0]  WSTRB_S,
  input  logic                     WLAST_S,
  input  logic                     WVALID_S,
  output logic                     WREADY_S,
  output logic [AxiIdWidth-1:0]    BID_S,
  output logic [1:0]               BRESP_S,
  output logic                     BVALID_S,
  input  logic                     BREADY_S,
  input  logic [AxiIdWidth-1:0]    ARID_S,
  input  logic [AxiAddrWidth-1:0]  ARADDR_S,
  input  logic [AxiLenWidth-1:0]   ARLEN_S,
  input  logic [2:0]               ARSIZE_S,
  input  logic [1:0]               ARBURST_S,
  input  logic                     ARVALID_S,
  output logic                     ARREADY_S,
  output logic [AxiIdWidth-1:0]    RID_S,
  output logic [AxiDataWidth-1:0]  RDATA_S,
  output logic [1:0]               RRESP_S,
  output logic                     RLAST_S,
  output logic                     RVALID_S,
  input  logic                     RREADY_S,
  output logic                     mem_cs,
  output logic [AxiStrbWidth-1:0]  mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [AxiDataWidth-1:0]  mem_wdata,
  input  logic [AxiDataWidth-1:0]  mem_rdata
);

  slv_state_e               state_q;
  logic [AxiIdWidth-1:0]    id_q;
  logic [AxiLenWidth-1:0]   len_q;
  logic [AxiLenWidth-1:0]   cnt_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic                     err_q;

  logic aw_gnt;
  logic ar_gnt;
  logic last_beat;
  logic w_hs;

  // Size and burst type are not honoured; only the word-address bits are kept.
  logic unused_ok;
  assign unused_ok = ^{AWSIZE_S, AWBURST_S, ARSIZE_S, ARBURST_S,
                       AWADDR_S[AxiAddrWidth-1:MEM_ADDR_BITS+2], AWADDR_S[1:0],
                       ARADDR_S[AxiAddrWidth-1:MEM_ADDR_BITS+2], ARADDR_S[1:0]};

  axi_slave_arb u_arb (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .en_i     (state_q == StIdle),
    .aw_req_i (AWVALID_S),
    .ar_req_i (ARVALID_S),
    .aw_gnt_o (aw_gnt),
    .ar_gnt_o (ar_gnt)
  );

  assign last_beat = (cnt_q == len_q);
  assign w_hs      = (state_q == StWData) & WVALID_S;

  always_comb begin
    AWREADY_S = aw_gnt;
    ARREADY_S = ar_gnt;
    WREADY_S  = (state_q == StWData);
    BVALID_S  = (state_q == StBResp);
    BID_S     = BVALID_S ? id_q : '0;
    BRESP_S   = BVALID_S ? (err_q ? RespSlvErr : RespOkay) : RespOkay;
    RVALID_S  = (state_q == StRData);
    RID_S     = RVALID_S ? id_q : '0;
    RDATA_S   = RVALID_S ? mem_rdata : '0;
    RRESP_S   = RespOkay;
    RLAST_S   = RVALID_S & last_beat;
    mem_cs    = w_hs | (state_q == StRFetch);
    mem_we    = w_hs ? WSTRB_S : '0;
    mem_addr  = mem_cs ? addr_q : '0;
    mem_wdata = w_hs ? WDATA_S : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aw_gnt) begin
            id_q    <= AWID_S;
            len_q   <= AWLEN_S;
            addr_q  <= AWADDR_S[MEM_ADDR_BITS+1:2];
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StWData;
          end else if (ar_gnt) begin
            id_q    <= ARID_S;
            len_q   <= ARLEN_S;
            addr_q  <= ARADDR_S[MEM_ADDR_BITS+1:2];
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StRFetch;
          end
        end
        StWData: begin
          if (WVALID_S) begin
            // Burst length comes from AWLEN; WLAST only flags a protocol error.
            if (WLAST_S != last_beat) err_q <= 1'b1;
            addr_q <= addr_q + MEM_ADDR_BITS'(1);
            if (last_beat) state_q <= StBResp;
            else           cnt_q   <= cnt_q + 4'd1;
          end
        end
        StBResp: begin
          if (BREADY_S) state_q <= StIdle;
        end
        StRFetch: begin
          state_q <= StRData;
        end
        StRData: begin
          if (RREADY_S) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              addr_q  <= addr_q + MEM_ADDR_BITS'(1);
              cnt_q   <= cnt_q + 4'd1;
              state_q <= StRFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_if.sv
// Directed bench for axi_slave_mem_if: burst vector table plus arbitration and reset sequences.
module tb_axi_slave_mem_if;
  import axi_slave_pkg::*;

  localparam int unsigned MemBits = 14;
  localparam int SAw = 0, SAr = 1, SW = 2, SB = 3, SR = 4;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [7:0]  AWID_S, ARID_S, BID_S, RID_S;
  logic [31:0] AWADDR_S, ARADDR_S, WDATA_S, RDATA_S, mem_wdata, mem_rdata;
  logic [3:0]  AWLEN_S, ARLEN_S, WSTRB_S, mem_we;
  logic [2:0]  AWSIZE_S, ARSIZE_S;
  logic [1:0]  AWBURST_S, ARBURST_S, BRESP_S, RRESP_S;
  logic AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;
  logic ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, mem_cs;
  logic [MemBits-1:0] mem_addr;

  axi_slave_mem_if #(.MEM_ADDR_BITS(MemBits)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
    .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  // SRAM model plus a log of every strobe the DUT issues.
  typedef struct packed {
    logic [MemBits-1:0] addr;
    logic [3:0]         we;
    logic [31:0]        wdata;
  } acc_t;

  logic [31:0] mem [0:(1<<MemBits)-1];
  acc_t log_q[$];

  always @(posedge ACLK) begin
    if (mem_cs) begin
      log_q.push_back({mem_addr, mem_we, mem_wdata});
      if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {AWREADY_S, WREADY_S, BVALID_S, ARREADY_S, RVALID_S, RLAST_S, mem_cs, mem_we,
            BID_S, BRESP_S, RID_S, RRESP_S, RDATA_S, mem_addr, mem_wdata};
  endfunction

  function automatic logic sig_sel(input int s);
    case (s)
      SAw:     return AWREADY_S;
      SAr:     return ARREADY_S;
      SW:      return WREADY_S;
      SB:      return BVALID_S;
      default: return RVALID_S;
    endcase
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_sig(input int s, input string name);
    int n = 0;
    #1;
    while (!sig_sel(s) && n < 40) begin
      @(posedge ACLK);
      #2;
      n++;
    end
    if (!sig_sel(s)) begin
      total++;
      bad++;
      $display("FAIL timeout %s: got 0 expected 1 within 40 cycles", name);
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    AWVALID_S = 0; ARVALID_S = 0; WVALID_S = 0; WLAST_S = 0; BREADY_S = 0; RREADY_S = 0;
    repeat (2) tick();
    ARESET = 1'b0;
    tick();
  endtask

  task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input int len);
    AWID_S = id; AWADDR_S = addr; AWLEN_S = 4'(len); AWSIZE_S = 3'd2; AWBURST_S = 2'b01;
    AWVALID_S = 1'b1;
    wait_sig(SAw, "awready");
    tick();
    AWVALID_S = 1'b0;
  endtask

  task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr, input int len);
    ARID_S = id; ARADDR_S = addr; ARLEN_S = 4'(len); ARSIZE_S = 3'd2; ARBURST_S = 2'b01;
    ARVALID_S = 1'b1;
    wait_sig(SAr, "arready");
    tick();
    ARVALID_S = 1'b0;
  endtask

  task automatic w_phase(input int len, input int wlast_beat, input logic [31:0] base,
                         input logic [3:0] strb);
    for (int i = 0; i <= len; i++) begin
      WDATA_S = base + 32'(i); WSTRB_S = strb; WLAST_S = (i == wlast_beat); WVALID_S = 1'b1;
      wait_sig(SW, "wready");
      tick();
    end
    WVALID_S = 1'b0;
    WLAST_S  = 1'b0;
  endtask

  task automatic b_phase(input logic [7:0] id, input logic [1:0] resp);
    BREADY_S = 1'b1;
    wait_sig(SB, "bvalid");
    check("bid", BID_S, id);
    check("bresp", BRESP_S, resp);
    tick();
    BREADY_S = 1'b0;
    check("bvalid drop", BVALID_S, 0);
  endtask

  task automatic r_phase(input logic [7:0] id, input int len, input logic [31:0] base,
                         input int stall_beat);
    int n0;
    for (int i = 0; i <= len; i++) begin
      RREADY_S = 1'b0;
      wait_sig(SR, "rvalid");
      check("rdata", RDATA_S, base + 32'(i));
      check("rlast", RLAST_S, (i == len));
      check("rid", RID_S, id);
      check("rresp", RRESP_S, RespOkay);
      if (i == stall_beat) begin
        n0 = log_q.size();
        repeat (3) begin
          tick();
          check("rdata held", RDATA_S, base + 32'(i));
          check("rvalid held", RVALID_S, 1);
          check("rlast held", RLAST_S, (i == len));
        end
        check("no fetch while stalled", log_q.size(), n0);
      end
      RREADY_S = 1'b1;
      tick();
      RREADY_S = 1'b0;
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  id;
    logic [31:0] addr;
    int          len;
    int          wlast;
    logic [31:0] base;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [13:0] word0;
    int          stall;
  } vec_t;

  vec_t vec[8];

  initial begin
    logic [MemBits-1:0] wa;
    int n0;

    vec[0] = '{1'b1, 8'h5A, 32'h0000_0100, 3, 3,  32'hA0, 4'hF, RespOkay,   14'h0040, -1};
    vec[1] = '{1'b0, 8'h33, 32'h0000_0100, 3, -1, 32'hA0, 4'h0, RespOkay,   14'h0040, 1};
    vec[2] = '{1'b1, 8'h11, 32'h0000_0200, 3, 2,  32'hB0, 4'hF, RespSlvErr, 14'h0080, -1};
    vec[3] = '{1'b0, 8'h12, 32'h0000_0200, 3, -1, 32'hB0, 4'h0, RespOkay,   14'h0080, -1};
    vec[4] = '{1'b1, 8'h7E, 32'h0000_FFFC, 1, 1,  32'hC0, 4'hF, RespOkay,   14'h3FFF, -1};
    vec[5] = '{1'b0, 8'h7F, 32'h0000_FFFC, 1, -1, 32'hC0, 4'h0, RespOkay,   14'h3FFF, -1};
    vec[6] = '{1'b1, 8'h06, 32'h0000_0008, 0, 0,  32'hD0, 4'h3, RespOkay,   14'h0002, -1};
    vec[7] = '{1'b1, 8'h07, 32'h0000_000C, 0, -1, 32'hE0, 4'hF, RespSlvErr, 14'h0003, -1};

    AWID_S = 0; AWADDR_S = 0; AWLEN_S = 0; AWSIZE_S = 0; AWBURST_S = 0; AWVALID_S = 0;
    ARID_S = 0; ARADDR_S = 0; ARLEN_S = 0; ARSIZE_S = 0; ARBURST_S = 0; ARVALID_S = 0;
    WDATA_S = 0; WSTRB_S = 0; WLAST_S = 0; WVALID_S = 0; BREADY_S = 0; RREADY_S = 0;
    ARESET = 1'b1;
    repeat (3) tick();
    check("reset outputs", outs(), 0);
    ARESET = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      log_q.delete();
      if (vec[v].is_wr) begin
        aw_phase(vec[v].id, vec[v].addr, vec[v].len);
        w_phase(vec[v].len, vec[v].wlast, vec[v].base, vec[v].strb);
        b_phase(vec[v].id, vec[v].resp);
        check("write beat count", log_q.size(), vec[v].len + 1);
        for (int i = 0; i < log_q.size() && i <= vec[v].len; i++) begin
          wa = vec[v].word0 + MemBits'(i);
          check("write addr", log_q[i].addr, wa);
          check("write strb", log_q[i].we, vec[v].strb);
          check("write data", log_q[i].wdata, vec[v].base + 32'(i));
        end
      end else begin
        ar_phase(vec[v].id, vec[v].addr, vec[v].len);
        r_phase(vec[v].id, vec[v].len, vec[v].base, vec[v].stall);
        check("read fetch count", log_q.size(), vec[v].len + 1);
        for (int i = 0; i < log_q.size() && i <= vec[v].len; i++) begin
          wa = vec[v].word0 + MemBits'(i);
          check("read addr", log_q[i].addr, wa);
          check("read we", log_q[i].we, 0);
        end
      end
    end

    // Simultaneous AW/AR requests alternate, write first after reset.
    do_reset();
    AWID_S = 8'h21; AWADDR_S = 32'h300; AWLEN_S = 0; AWVALID_S = 1'b1;
    ARID_S = 8'h22; ARADDR_S = 32'h100; ARLEN_S = 0; ARVALID_S = 1'b1;
    #1;
    check("arb1 awready", AWREADY_S, 1);
    check("arb1 arready", ARREADY_S, 0);
    tick();
    AWVALID_S = 1'b0;
    #1;
    check("ar waits during write", ARREADY_S, 0);
    w_phase(0, 0, 32'h77, 4'hF);
    b_phase(8'h21, RespOkay);
    AWID_S = 8'h23; AWADDR_S = 32'h304; AWVALID_S = 1'b1;
    #1;
    check("arb2 arready", ARREADY_S, 1);
    check("arb2 awready", AWREADY_S, 0);
    tick();
    ARVALID_S = 1'b0;
    #1;
    check("aw waits during read", AWREADY_S, 0);
    r_phase(8'h22, 0, 32'hA0, -1);
    ARID_S = 8'h24; ARADDR_S = 32'h300; ARVALID_S = 1'b1;
    #1;
    check("arb3 awready", AWREADY_S, 1);
    check("arb3 arready", ARREADY_S, 0);
    tick();
    AWVALID_S = 1'b0;
    w_phase(0, 0, 32'h78, 4'hF);
    b_phase(8'h23, RespOkay);
    wait_sig(SAr, "arready after arb3");
    tick();
    ARVALID_S = 1'b0;
    r_phase(8'h24, 0, 32'h77, -1);

    // Reset asserted on the second beat of a write burst.
    do_reset();
    aw_phase(8'h44, 32'h400, 3);
    WDATA_S = 32'hF0; WSTRB_S = 4'hF; WLAST_S = 1'b0; WVALID_S = 1'b1;
    wait_sig(SW, "wready beat1");
    tick();
    WDATA_S = 32'hF1;
    ARESET = 1'b1;
    tick();
    check("outputs after mid-burst reset", outs(), 0);
    ARESET = 1'b0;
    n0 = log_q.size();
    repeat (4) begin
      tick();
      check("no strobe after reset", mem_cs, 0);
      check("no wready after reset", WREADY_S, 0);
      check("no bvalid after reset", BVALID_S, 0);
    end
    check("no writes after reset", log_q.size(), n0);
    WVALID_S = 1'b0;
    log_q.delete();
    aw_phase(8'h55, 32'h500, 0);
    w_phase(0, 0, 32'h99, 4'hF);
    b_phase(8'h55, RespOkay);
    check("post-reset write count", log_q.size(), 1);
    if (log_q.size() > 0) check("post-reset write addr", log_q[0].addr, 14'h0140);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem_if.md
AXI_SLAVE_MEM_IF -- requirements
Module: axi_slave_mem_if

Interface
REQ-001 Parameter: MEM_ADDR_BITS, default 14, word-address width of the attached SRAM (64 KiB).
REQ-002 ACLK  in  1  system clock; all state updates on rising edge.
REQ-003 ARESET  in  1  reset; the block SHALL use one clock, and reset is synchronous and active-high.
REQ-004 AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S/AWVALID_S  in  8/32/4/3/2/1  write-address channel; AWREADY_S  out  1.
REQ-005 WDATA_S/WSTRB_S/WLAST_S/WVALID_S  in  32/4/1/1  write-data channel; WREADY_S  out  1.
REQ-006 BID_S/BRESP_S/BVALID_S  out  8/2/1  write response; BREADY_S  in  1.
REQ-007 ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S/ARVALID_S  in  8/32/4/3/2/1  read-address channel; ARREADY_S  out  1.
REQ-008 RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S  out  8/32/2/1/1  read-data channel; RREADY_S  in  1.
REQ-009 mem_cs  out  1  memory access strobe; mem_we  out  4  byte write enables (0 = read); mem_addr  out  MEM_ADDR_BITS  word address; mem_wdata  out  32; mem_rdata  in  32, valid the cycle after a read strobe and held until the next mem_cs.

Function
REQ-010 FSM states: IDLE, W_DATA, B_RESP, R_FETCH, R_DATA; one transaction in flight at a time.
REQ-011 IDLE: AWREADY_S=1 and ARREADY_S=1 only when the arbiter grants that channel; all other channel outputs low.
REQ-012 Arbitration in IDLE: single request wins; both AWVALID_S and ARVALID_S high -> grant the channel not granted last (toggle flag, reset value = read last, so write wins first).
REQ-013 Address handshake SHALL latch ID, LEN, word address ADDR[MEM_ADDR_BITS+1:2] and clear beat counter; AW -> W_DATA, AR -> R_FETCH next cycle.
REQ-014 AWSIZE/ARSIZE SHALL be ignored (4-byte beats); every AWBURST/ARBURST value SHALL be treated as INCR.
REQ-015 Word address increments by 1 per completed beat, wrapping modulo 2^MEM_ADDR_BITS.
REQ-016 W_DATA: WREADY_S=1; on WVALID_S&WREADY_S drive mem_cs=1, mem_we=WSTRB_S, mem_wdata=WDATA_S, mem_addr=current address in the same cycle.
REQ-017 Burst ends on the beat with counter==LEN -> B_RESP; WLAST_S mismatch (early, or absent on final beat) SHALL set a sticky error flag; extra beats are not accepted.
REQ-018 B_RESP: BVALID_S=1, BID_S=latched ID, BRESP_S=2'b10 if error flag else 2'b00; held until BREADY_S; then IDLE.
REQ-019 R_FETCH: mem_cs=1, mem_we=0, mem_addr=current address, one cycle -> R_DATA.
REQ-020 R_DATA: RVALID_S=1, RDATA_S=mem_rdata, RID_S=latched ID, RRESP_S=2'b00, RLAST_S=(counter==LEN); held stable until RREADY_S.
REQ-021 On R handshake: last beat -> IDLE, else increment address/counter -> R_FETCH; throughput 2 cycles per read beat, 1 cycle per write beat.
REQ-022 mem_cs SHALL be 0 in IDLE, B_RESP and R_DATA; no memory write outside a W handshake.
REQ-023 Requests arriving during a transaction SHALL wait with READY low; no address is lost.

Reset
REQ-024 ARESET sampled high SHALL force IDLE at that edge, clear counter/error flag, arbiter flag = read last; every output 0 (AWREADY_S, WREADY_S, BVALID_S, ARREADY_S, RVALID_S, RLAST_S, mem_cs, mem_we, IDs, RESP, data).
REQ-025 Reset mid-burst SHALL abandon the burst with no further memory strobe and no B/R response.

Structure
REQ-026 State enum and AXI width constants (ID 8, ADDR 32, DATA 32, LEN 4, STRB 4, RESP codes OKAY/SLVERR) SHALL live in shared package axi_slave_pkg.
REQ-027 One sub-module: axi_slave_arb (two-request round-robin arbiter with last-grant flag).

Verification
REQ-028 AW addr 0x100, LEN 3, four W beats data 0xA0..0xA3 strobe 0xF, WLAST on 4th -> mem writes to word 0x40..0x43, BRESP 00, BID echoes AWID.
REQ-029 AR addr 0x100, LEN 3, RREADY stalled 3 cycles on beat 1 -> RDATA 0xA0..0xA3 held stable while stalled, RLAST only on 4th beat.
REQ-030 AWVALID and ARVALID asserted same cycle twice in a row -> write granted first, read second, then write.
REQ-031 WLAST on beat 2 of LEN 3 burst -> four beats still written, BRESP 2'b10.
REQ-032 AR word address 0x3FFF, LEN 1 -> mem_addr 0x3FFF then 0x0000.
REQ-033 ARESET high during W beat 2 -> next cycle all outputs 0, no further mem_cs, new AW accepted after release.
